// File: rtl/seq_detector_param.sv
// ----------------------------------------------------------------------------
// seq_detector_param
//
// Serial pattern detector. Accepted bits (in_valid=1) are shifted into a
// history register. A match is flagged combinationally in the same cycle that
// the final pattern bit is presented. Matches are counted in a saturating
// counter with a sticky saturation flag.
//
// Parameters
//   PAT_W    : pattern length in bits (2..32)
//   PATTERN  : target sequence, MSB is the first bit received
//   CNT_W    : match counter width (1..32)
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   in_bit     : serial data bit
//   in_valid   : qualifies in_bit
//   overlap_en : 1 = overlapping matches allowed, 0 = non-overlapping
//   clear_cnt  : synchronous clear of match_cnt and cnt_sat
//   out        : Mealy match flag (combinational)
//   out_q      : out delayed by one cycle
//   match_cnt  : number of matches since reset or last clear
//   cnt_sat    : sticky flag, set once match_cnt has saturated
// ----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int unsigned       PAT_W   = 5,
    parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(5'b11010),
    parameter int unsigned       CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             overlap_en,
    input  logic             clear_cnt,
    output logic             out,
    output logic             out_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    // Reject parameter values the datapath cannot represent.
    generate
        if (PAT_W < 2 || PAT_W > 32) begin : gBadPatW
            $fatal(1, "seq_detector_param: PAT_W=%0d outside legal range 2..32", PAT_W);
        end
        if (CNT_W < 1 || CNT_W > 32) begin : gBadCntW
            $fatal(1, "seq_detector_param: CNT_W=%0d outside legal range 1..32", CNT_W);
        end
    endgenerate

    // Fill count saturates at PAT_W-1, so $clog2(PAT_W) bits are enough.
    localparam int unsigned FILL_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  history_q, history_d;
    logic [FILL_W-1:0] fillCnt_q, fillCnt_d;
    logic              outReg_q;
    logic [CNT_W-1:0]  matchCnt_q, matchCnt_d;
    logic              cntSat_q, cntSat_d;

    logic              fillFull;
    logic [PAT_W-1:0]  candidate;
    logic              match;

    // The candidate window is the stored history with the incoming bit as LSB.
    // A match needs a full history so stale or partial bits never count.
    assign fillFull  = (fillCnt_q == FILL_FULL);
    assign candidate = {history_q, in_bit};
    assign match     = in_valid && fillFull && (candidate == PATTERN);

    // Next-state for history and fill count. Non-overlap mode empties the
    // fill count on a match so the next match needs PAT_W fresh bits;
    // overlap_en is only consulted on match edges.
    always_comb begin
        history_d = history_q;
        fillCnt_d = fillCnt_q;
        if (in_valid) begin
            history_d = candidate[PAT_W-2:0];
            if (match && !overlap_en) begin
                fillCnt_d = '0;
            end else if (!fillFull) begin
                fillCnt_d = fillCnt_q + 1'b1;
            end
        end
    end

    // Next-state for the match counter. Clear wins over a coincident match;
    // a match at all-ones holds the count and raises the sticky flag.
    always_comb begin
        matchCnt_d = matchCnt_q;
        cntSat_d   = cntSat_q;
        if (clear_cnt) begin
            matchCnt_d = '0;
            cntSat_d   = 1'b0;
        end else if (match) begin
            if (&matchCnt_q) begin
                cntSat_d = 1'b1;
            end else begin
                matchCnt_d = matchCnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any partial history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history_q  <= '0;
            fillCnt_q  <= '0;
            outReg_q   <= 1'b0;
            matchCnt_q <= '0;
            cntSat_q   <= 1'b0;
        end else begin
            history_q  <= history_d;
            fillCnt_q  <= fillCnt_d;
            outReg_q   <= match;
            matchCnt_q <= matchCnt_d;
            cntSat_q   <= cntSat_d;
        end
    end

    assign out       = match;
    assign out_q     = outReg_q;
    assign match_cnt = matchCnt_q;
    assign cnt_sat   = cntSat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// ----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Drives two detector instances with the same input stream:
//   dutA : default parameters (PATTERN 11010, CNT_W 8)
//   dutB : PAT_W 4, PATTERN 1011, CNT_W 2
// Expected outputs come from a reference model that keeps the list of all
// bits accepted since reset and a per-instance window start index, and
// compares the tail of that list to the pattern. Expectations are queued per
// cycle and popped by an independent monitor on the falling edge.
// ----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk;
    logic       reset;
    logic       in_bit;
    logic       in_valid;
    logic       overlap_en;
    logic       clear_cnt;

    logic       outA, outQA, satA;
    logic [7:0] cntA;
    logic       outB, outQB, satB;
    logic [1:0] cntB;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit out;
        bit outQ;
        int cnt;
        bit sat;
    } exp_t;

    exp_t sbA[$];
    exp_t sbB[$];

    // Reference model state.
    bit          acc[$];
    int          start[2];
    int          cnt[2];
    bit          sat[2];
    bit          prevOut[2];
    int          patW[2]   = '{5, 4};
    int unsigned patVal[2] = '{32'h1A, 32'hB};
    int          cntMax[2] = '{255, 3};

    seq_detector_param dutA (
        .clk        (clk),
        .reset      (reset),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .overlap_en (overlap_en),
        .clear_cnt  (clear_cnt),
        .out        (outA),
        .out_q      (outQA),
        .match_cnt  (cntA),
        .cnt_sat    (satA)
    );

    seq_detector_param #(
        .PAT_W   (4),
        .PATTERN (4'b1011),
        .CNT_W   (2)
    ) dutB (
        .clk        (clk),
        .reset      (reset),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .overlap_en (overlap_en),
        .clear_cnt  (clear_cnt),
        .out        (outB),
        .out_q      (outQB),
        .match_cnt  (cntB),
        .cnt_sat    (satB)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Last w accepted bits packed MSB-first.
    function automatic int unsigned lastBits(input int w);
        int unsigned v = 0;
        for (int i = acc.size() - w; i < acc.size(); i++) begin
            v = (v << 1) | int'(acc[i]);
        end
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expected outputs for that cycle,
    // then advance the model across the following rising edge.
    task automatic applyStimulus(input bit rstN, input bit v, input bit b,
                                 input bit ovl, input bit clr);
        bit   expOut[2];
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rstN;
        in_valid   = v;
        in_bit     = b;
        overlap_en = ovl;
        clear_cnt  = clr;
        if (!rstN) begin
            acc.delete();
            for (int d = 0; d < 2; d++) begin
                start[d]   = 0;
                cnt[d]     = 0;
                sat[d]     = 1'b0;
                prevOut[d] = 1'b0;
            end
        end else if (v) begin
            acc.push_back(b);
        end
        for (int d = 0; d < 2; d++) begin
            expOut[d] = rstN && v && (acc.size() - start[d] >= patW[d])
                        && (lastBits(patW[d]) == patVal[d]);
        end
        e.out = expOut[0]; e.outQ = prevOut[0]; e.cnt = cnt[0]; e.sat = sat[0];
        sbA.push_back(e);
        e.out = expOut[1]; e.outQ = prevOut[1]; e.cnt = cnt[1]; e.sat = sat[1];
        sbB.push_back(e);
        if (rstN) begin
            for (int d = 0; d < 2; d++) begin
                prevOut[d] = expOut[d];
                if (expOut[d] && !ovl) start[d] = acc.size();
                if (clr) begin
                    cnt[d] = 0;
                    sat[d] = 1'b0;
                end else if (expOut[d]) begin
                    if (cnt[d] == cntMax[d]) sat[d] = 1'b1;
                    else cnt[d] = cnt[d] + 1;
                end
            end
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle(input bit ovl);
        applyStimulus(1'b1, 1'b0, 1'b0, ovl, 1'b0);
    endtask

    // Monitor: compare every output the DUTs present against the queued
    // expectation, away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbA.size() > 0) begin
            e = sbA.pop_front();
            checkOutput("A.out",       int'(outA),  int'(e.out));
            checkOutput("A.out_q",     int'(outQA), int'(e.outQ));
            checkOutput("A.match_cnt", int'(cntA),  e.cnt);
            checkOutput("A.cnt_sat",   int'(satA),  int'(e.sat));
        end
        if (sbB.size() > 0) begin
            e = sbB.pop_front();
            checkOutput("B.out",       int'(outB),  int'(e.out));
            checkOutput("B.out_q",     int'(outQB), int'(e.outQ));
            checkOutput("B.match_cnt", int'(cntB),  e.cnt);
            checkOutput("B.cnt_sat",   int'(satB),  int'(e.sat));
        end
    end

    initial begin
        bit s31[20] = '{0,0,1,1,0,1,1,1,1,0,1,0,0,1,1,0,1,0,1,0};
        bit s32[7]  = '{1,0,1,1,0,1,1};
        bit s33[5]  = '{1,1,0,1,0};
        bit s34[4]  = '{1,0,1,1};
        bit ovl;
        bit rstN;

        reset      = 1'b0;
        in_bit     = 1'b0;
        in_valid   = 1'b0;
        overlap_en = 1'b1;
        clear_cnt  = 1'b0;

        // Reset state, with in_valid high to show out stays low.
        doReset();
        @(negedge clk); #1;
        checkOutput("resetOutA", int'(outA), 0);
        checkOutput("resetCntA", int'(cntA), 0);

        // Default pattern, overlap, continuous valid stream.
        doReset();
        foreach (s31[i]) applyStimulus(1'b1, 1'b1, s31[i], 1'b1, 1'b0);
        idle(1'b1);
        @(negedge clk); #1;
        checkOutput("streamCntA", int'(cntA), 2);

        // Four-bit pattern with overlap, then without.
        doReset();
        foreach (s32[i]) applyStimulus(1'b1, 1'b1, s32[i], 1'b1, 1'b0);
        idle(1'b1);
        @(negedge clk); #1;
        checkOutput("overlapCntB", int'(cntB), 2);
        doReset();
        foreach (s32[i]) applyStimulus(1'b1, 1'b1, s32[i], 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk); #1;
        checkOutput("noOverlapCntB", int'(cntB), 1);

        // Gaps in in_valid between bits 2 and 3.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, s33[i], 1'b1, 1'b0);
            if (i == 2) begin
                for (int g = 0; g < 3; g++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            end
        end
        idle(1'b1);
        @(negedge clk); #1;
        checkOutput("gapCntA", int'(cntA), 1);

        // Counter saturation on the 2-bit counter, then clear.
        doReset();
        for (int m = 0; m < 4; m++) begin
            foreach (s34[i]) applyStimulus(1'b1, 1'b1, s34[i], 1'b0, 1'b0);
        end
        idle(1'b0);
        @(negedge clk); #1;
        checkOutput("satCntB", int'(cntB), 3);
        checkOutput("satFlagB", int'(satB), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk); #1;
        checkOutput("clearCntB", int'(cntB), 0);
        checkOutput("clearSatB", int'(satB), 0);

        // Reset mid-pattern discards history.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, s33[i], 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1;
        checkOutput("midResetOutA", int'(outA), 0);

        // Clear coinciding with a match edge.
        doReset();
        foreach (s33[i]) applyStimulus(1'b1, 1'b1, s33[i], 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, s33[i], 1'b1, i == 4);
        @(negedge clk); #1;
        checkOutput("clearMatchOutA", int'(outA), 1);
        idle(1'b1);
        @(negedge clk); #1;
        checkOutput("clearMatchCntA", int'(cntA), 0);

        // Randomized traffic.
        doReset();
        ovl = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) ovl = ~ovl;
            rstN = ($urandom_range(0, 299) != 0);
            applyStimulus(rstN, $urandom_range(0, 3) != 0, 1'($urandom),
                          ovl, $urandom_range(0, 49) == 0);
        end
        idle(ovl);
        @(negedge clk); #1;
        checkOutput("drainA", sbA.size(), 0);
        checkOutput("drainB", sbB.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 5: pattern length in bits; legal range 2..32.
REQ-002 Parameter PATTERN, default 5'b11010: target sequence; MSB is the first bit received.
REQ-003 Parameter CNT_W, default 8: match counter width; legal range 1..32.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset; 0 resets all state immediately.
REQ-006 Port in_bit, input, 1: serial data bit, sampled when in_valid=1.
REQ-007 Port in_valid, input, 1: qualifies in_bit; 0 means no bit this cycle.
REQ-008 Port overlap_en, input, 1: 1 means overlapping matches are allowed; 0 means non-overlapping.
REQ-009 Port clear_cnt, input, 1: synchronous clear of match_cnt and cnt_sat.
REQ-010 Port out, output, 1: Mealy match flag, combinational from current state and inputs.
REQ-011 Port out_q, output, 1: registered copy of out, delayed by one cycle.
REQ-012 Port match_cnt, output, CNT_W: number of matches since reset or last clear.
REQ-013 Port cnt_sat, output, 1: sticky flag; 1 once match_cnt has saturated.

Function
REQ-014 The block SHALL keep a history register of the last PAT_W-1 accepted bits and a fill count of accepted bits, saturating at PAT_W-1.
REQ-015 out SHALL be 1 iff in_valid=1, fill count = PAT_W-1, and {history, in_bit} = PATTERN.
  - out has zero-cycle latency and asserts in the same cycle the final pattern bit is presented.
REQ-016 On each edge with in_valid=1, the block SHALL shift in_bit into the history and increment the fill count (saturating).
REQ-017 On each edge with in_valid=0, history and fill count SHALL hold; out SHALL be 0.
REQ-018 Overlap mode (overlap_en=1): after a match, history and fill count SHALL update normally, so pattern suffixes can begin the next match.
REQ-019 Non-overlap mode (overlap_en=0): on a match edge, the fill count SHALL be set to 0.
  - The next match therefore requires PAT_W fresh bits.
REQ-020 overlap_en SHALL be sampled only on match edges; changing it mid-stream affects the next match only.
REQ-021 out_q SHALL equal out from the previous cycle.
REQ-022 On a match edge, match_cnt SHALL increment by 1.
REQ-023 At all-ones, match_cnt SHALL hold its value and set cnt_sat=1.
REQ-024 cnt_sat SHALL stay 1 until reset or clear_cnt.
REQ-025 When clear_cnt=1 on an edge, match_cnt SHALL become 0 and cnt_sat SHALL become 0.
  - This applies even if a match occurs on the same edge: clear has priority and the match is not counted.
  - History and fill count still update per REQ-016 to REQ-019.
  - out is unaffected by clear_cnt.
REQ-026 An out-of-range PAT_W or CNT_W SHALL be rejected at elaboration with a fatal error.

Reset
REQ-027 While reset=0, the following SHALL hold:
  - history = 0
  - fill count = 0
  - out_q = 0
  - match_cnt = 0
  - cnt_sat = 0
REQ-028 Because the fill count is 0 during reset, out SHALL be 0 during reset.
REQ-029 Asserting reset mid-pattern SHALL discard all partial history; detection restarts from an empty history.
REQ-030 Reset deassertion is synchronised externally; the first accepted bit is on the first rising edge after reset=1.

Verification
REQ-031 Default parameters, overlap_en=1, in_valid=1, bit stream 0,0,1,1,0,1,1,1,1,0,1,0,0,1,1,0,1,0,1,0:
  - out=1 on bit indices 11 and 17 only; out_q=1 on indices 12 and 18.
  - match_cnt=2 at the end.
REQ-032 PATTERN=4'b1011, PAT_W=4, stream 1,0,1,1,0,1,1:
  - With overlap_en=1: out=1 on indices 3 and 6; match_cnt=2.
  - With overlap_en=0: out=1 on index 3 only; match_cnt=1.
REQ-033 Default parameters, stream 1,1,0,1,0 with in_valid=0 for 3 cycles between bits 2 and 3:
  - out=1 exactly once, on bit index 4.
  - out=0 during every in_valid=0 cycle.
REQ-034 CNT_W=2, 4 overlap-free matches:
  - match_cnt goes 1, 2, 3, 3.
  - cnt_sat=1 after the fourth match.
  - After clear_cnt=1 for one cycle: match_cnt=0 and cnt_sat=0.
REQ-035 Reset and clear corner cases:
  - reset=0 asserted after 1,1,0,1 of the default pattern, then released and 0 presented: out=0.
  - In a separate run, clear_cnt=1 on a match edge: out=1, and match_cnt=0 after that edge.
